// File: rtl/key_band_tracker.sv
// Raster-line band tracker for the keyboard bar display.
// It follows the row sequence with a per-line counter and produces registered band, gap, highlight and sync-loss outputs.
module key_band_tracker #(
    parameter int NUM_KEYS = 15,
    parameter int BAND_H   = 30,
    parameter int GAP_H    = 2,
    parameter int Y_W      = 12,
    parameter int Y_START  = 0,
    localparam int PITCH   = BAND_H + GAP_H,
    localparam int IW      = $clog2(NUM_KEYS + 1),
    localparam int PW      = $clog2(PITCH)
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iLINE_STB,
    input  logic                iFRAME_START,
    input  logic [Y_W-1:0]      iCOUNTER_Y,
    input  logic [NUM_KEYS-1:0] iKEY_ON,
    input  logic                iCLR_ERR,
    output logic [NUM_KEYS-1:0] oBAND,
    output logic [IW-1:0]       oBAND_IDX,
    output logic                oGAP,
    output logic                oHIT,
    output logic                oSYNC_ERR
);

    localparam logic [IW-1:0]  NK_P      = IW'(NUM_KEYS);
    localparam logic [PW:0]    PITCH_P   = (PW + 1)'(PITCH);
    localparam logic [PW:0]    BAND_H_P  = (PW + 1)'(BAND_H);
    localparam logic [Y_W-1:0] Y_START_P = Y_W'(Y_START);

    typedef enum logic [1:0] {SEARCH, TRACK, PAST} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [Y_W-1:0]      last_row_q, last_row_d;
    logic [NUM_KEYS-1:0] key_snap_q, key_snap_d;
    logic [NUM_KEYS-1:0] band_q, band_d;
    logic [IW-1:0]       band_idx_q, band_idx_d;
    logic                gap_q, gap_d;
    logic                hit_q, hit_d;
    logic                sync_err_q, sync_err_d;
    logic                seq_ok;
    logic [PW:0]         pos_inc;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        last_row_d = last_row_q;
        band_d     = band_q;
        band_idx_d = band_idx_q;
        gap_d      = gap_q;
        hit_d      = hit_q;
        key_snap_d = iFRAME_START ? iKEY_ON : key_snap_q;
        // A clear only survives when no mismatch is raised in the same cycle.
        sync_err_d = sync_err_q & ~iCLR_ERR;
        seq_ok     = (iCOUNTER_Y == last_row_q + Y_W'(1));
        pos_inc    = {1'b0, pos_q} + (PW + 1)'(1);

        if (iLINE_STB) begin
            last_row_d = iCOUNTER_Y;
            if (iCOUNTER_Y == Y_START_P) begin
                state_d = TRACK;
                idx_d   = '0;
                pos_d   = '0;
            end else begin
                case (state_q)
                    TRACK: begin
                        if (!seq_ok) begin
                            state_d    = SEARCH;
                            sync_err_d = 1'b1;
                        end else if (pos_inc == PITCH_P) begin
                            pos_d = '0;
                            idx_d = idx_q + 1'b1;
                            if (idx_d == NK_P) state_d = PAST;
                        end else begin
                            pos_d = pos_inc[PW-1:0];
                        end
                    end
                    PAST: begin
                        if (!seq_ok) begin
                            state_d    = SEARCH;
                            sync_err_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Outputs decode the position just computed for this row.
            band_d     = '0;
            band_idx_d = NK_P;
            gap_d      = 1'b0;
            hit_d      = 1'b0;
            if (state_d == TRACK) begin
                if ({1'b0, pos_d} < BAND_H_P) begin
                    band_idx_d = idx_d;
                    for (int k = 0; k < NUM_KEYS; k++) begin
                        band_d[k] = (idx_d == IW'(k));
                        hit_d     = hit_d | ((idx_d == IW'(k)) & key_snap_d[k]);
                    end
                end else begin
                    gap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= SEARCH;
            idx_q      <= '0;
            pos_q      <= '0;
            last_row_q <= '0;
            key_snap_q <= '0;
            band_q     <= '0;
            band_idx_q <= NK_P;
            gap_q      <= 1'b0;
            hit_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            last_row_q <= last_row_d;
            key_snap_q <= key_snap_d;
            band_q     <= band_d;
            band_idx_q <= band_idx_d;
            gap_q      <= gap_d;
            hit_q      <= hit_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign oBAND     = band_q;
    assign oBAND_IDX = band_idx_q;
    assign oGAP      = gap_q;
    assign oHIT      = hit_q;
    assign oSYNC_ERR = sync_err_q;

endmodule

// File: tb/tb_key_band_tracker.sv
// Directed bench for key_band_tracker: default geometry plus an 8-band instance fed the same rows.
module tb_key_band_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        fstart = 1'b0;
    logic        clr = 1'b0;
    logic [11:0] cy = '0;
    logic [14:0] key_on = '0;

    logic [14:0] band1;
    logic [3:0]  idx1;
    logic        gap1, hit1, err1;
    logic [7:0]  band2;
    logic [3:0]  idx2;
    logic        gap2, hit2, err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_band_tracker dut1 (
        .iCLK(clk), .iRST(rst), .iLINE_STB(stb), .iFRAME_START(fstart),
        .iCOUNTER_Y(cy), .iKEY_ON(key_on), .iCLR_ERR(clr),
        .oBAND(band1), .oBAND_IDX(idx1), .oGAP(gap1), .oHIT(hit1), .oSYNC_ERR(err1)
    );

    key_band_tracker #(.NUM_KEYS(8), .BAND_H(20), .GAP_H(4), .Y_W(12), .Y_START(10)) dut2 (
        .iCLK(clk), .iRST(rst), .iLINE_STB(stb), .iFRAME_START(fstart),
        .iCOUNTER_Y(cy), .iKEY_ON(key_on[7:0]), .iCLR_ERR(clr),
        .oBAND(band2), .oBAND_IDX(idx2), .oGAP(gap2), .oHIT(hit2), .oSYNC_ERR(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input int y, input logic fs, input logic c);
        @(negedge clk);
        cy = 12'(y);
        stb = 1'b1;
        fstart = fs;
        clr = c;
        @(posedge clk);
        #1;
        stb = 1'b0;
        fstart = 1'b0;
        clr = 1'b0;
    endtask

    task automatic chk1(input string tag, input logic [14:0] b, input logic [3:0] i,
                        input logic g, input logic h);
        chk({tag, ".band"}, 32'(band1), 32'(b));
        chk({tag, ".idx"},  32'(idx1),  32'(i));
        chk({tag, ".gap"},  32'(gap1),  32'(g));
        chk({tag, ".hit"},  32'(hit1),  32'(h));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk1("reset", 15'h0000, 4'd15, 1'b0, 1'b0);
        chk("reset.err", 32'(err1), 32'd0);

        // Track part of a frame, then reset asynchronously at row 100.
        for (int y = 0; y <= 100; y++) line(y, 1'b0, 1'b0);
        chk1("row100", 15'h0008, 4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk1("midrst", 15'h0000, 4'd15, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        line(101, 1'b0, 1'b0);
        chk1("search101", 15'h0000, 4'd15, 1'b0, 1'b0);
        line(102, 1'b0, 1'b0);
        chk1("search102", 15'h0000, 4'd15, 1'b0, 1'b0);

        // Full frame; snapshot taken on the same cycle as row 0, live keys dropped later.
        key_on = 15'h0005;
        for (int y = 0; y <= 511; y++) begin
            line(y, y == 0, 1'b0);
            if (y == 11) key_on = 15'h0000;
            if (y == 0)   chk1("row0",   15'h0001, 4'd0,  1'b0, 1'b1);
            if (y == 29)  chk1("row29",  15'h0001, 4'd0,  1'b0, 1'b1);
            if (y == 30)  chk1("row30",  15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 31)  chk1("row31",  15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 32)  chk1("row32",  15'h0002, 4'd1,  1'b0, 1'b0);
            if (y == 63)  chk1("row63",  15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 64)  chk1("row64",  15'h0004, 4'd2,  1'b0, 1'b1);
            if (y == 93)  chk1("row93",  15'h0004, 4'd2,  1'b0, 1'b1);
            if (y == 94)  chk1("row94",  15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 96)  chk1("row96",  15'h0008, 4'd3,  1'b0, 1'b0);
            if (y == 477) chk1("row477", 15'h4000, 4'd14, 1'b0, 1'b0);
            if (y == 478) chk1("row478", 15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 479) chk1("row479", 15'h0000, 4'd15, 1'b1, 1'b0);
            if (y == 480) chk1("row480", 15'h0000, 4'd15, 1'b0, 1'b0);
            if (y == 9) begin
                chk("k8.row9.band", 32'(band2), 32'h00);
                chk("k8.row9.idx",  32'(idx2),  32'd8);
            end
            if (y == 10) begin
                chk("k8.row10.band", 32'(band2), 32'h01);
                chk("k8.row10.idx",  32'(idx2),  32'd0);
            end
            if (y == 30) chk("k8.row30.gap", 32'(gap2), 32'd1);
            if (y == 34) begin
                chk("k8.row34.band", 32'(band2), 32'h02);
                chk("k8.row34.idx",  32'(idx2),  32'd1);
            end
            if (y == 202) begin
                chk("k8.row202.band", 32'(band2), 32'h00);
                chk("k8.row202.idx",  32'(idx2),  32'd8);
                chk("k8.row202.gap",  32'(gap2),  32'd0);
            end
        end
        chk("row511.err", 32'(err1), 32'd0);
        chk1("row511", 15'h0000, 4'd15, 1'b0, 1'b0);

        // Row jump 40 -> 45 during tracking.
        for (int y = 0; y <= 40; y++) line(y, 1'b0, 1'b0);
        chk1("row40", 15'h0002, 4'd1, 1'b0, 1'b0);
        chk("row40.err", 32'(err1), 32'd0);
        line(45, 1'b0, 1'b0);
        chk1("jump45", 15'h0000, 4'd15, 1'b0, 1'b0);
        chk("jump45.err", 32'(err1), 32'd1);
        line(46, 1'b0, 1'b0);
        chk1("after46", 15'h0000, 4'd15, 1'b0, 1'b0);
        line(0, 1'b0, 1'b0);
        chk1("resume0", 15'h0001, 4'd0, 1'b0, 1'b1);
        chk("resume0.err", 32'(err1), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr.err", 32'(err1), 32'd0);
        line(1, 1'b0, 1'b0);
        chk("row1.err", 32'(err1), 32'd0);
        line(7, 1'b0, 1'b1);
        chk("setwins.err", 32'(err1), 32'd1);
        chk1("setwins", 15'h0000, 4'd15, 1'b0, 1'b0);
        line(8, 1'b0, 1'b1);
        chk("clr2.err", 32'(err1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
